quickq_scheduler: RTL and testbench

QUICKQ_SCHEDULER -- requirements
Module: quickq_scheduler

---
 rtl/quickq_scheduler.sv | 93 +++++++++
 tb/tb_quickq_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/quickq_scheduler.sv
// quickq_scheduler: two-port round-robin front end that sequences one enqueue/dequeue at a time into a quickQ core.
// Define QQ_SCHED_DEQ_PRIO_EN to let a lone dequeue requester win over an enqueue requester.
module quickq_scheduler #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 8,
    parameter int OP_LAT = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              core_enq,
    output logic              core_deq,
    output logic              core_regenb,
    output logic [1:0]        core_mux1_sel,
    output logic [DATA_W-1:0] core_to_register,
    output logic              core_next_node,
    input  logic [DATA_W-1:0] core_data_lt_o,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic rr_ptr, port_q, op_q, err_q, win, hs, rej;
    logic [DATA_W-1:0] data_q;
    logic [3:0] wait_cnt;
`ifdef QQ_SCHED_DEQ_PRIO_EN
    assign win = (&req_valid && (req_op[0] ^ req_op[1])) ? req_op[1] : (req_valid[rr_ptr] ? rr_ptr : ~rr_ptr);
`else
    assign win = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
`endif
    assign hs = (state == IDLE) && req_valid[win];
    assign rej = req_op[win] ? empty : full;
    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = !hs ? IDLE : rej ? DONE : req_op[win] ? ISSUE : LOAD;
            LOAD:    state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (wait_cnt == 4'(OP_LAT - 1)) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready = hs ? (win ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid = (state == DONE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
        rsp_err = (state == DONE) && err_q;
        core_regenb = (state == LOAD);
        core_enq = (state == ISSUE) && !op_q;
        core_deq = (state == ISSUE) && op_q;
        core_mux1_sel = (state == LOAD) ? 2'b01 : ((state == ISSUE) && op_q) ? 2'b10 : 2'b00;
        core_to_register = (state == LOAD) ? data_q : '0;
        core_next_node = (state == WAIT);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
            port_q <= 1'b0;
            op_q <= 1'b0;
            err_q <= 1'b0;
            data_q <= '0;
            wait_cnt <= '0;
            count <= '0;
            rsp_data <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= ~win;
                port_q <= win;
                op_q <= req_op[win];
                err_q <= rej;
                data_q <= win ? req_data1 : req_data0;
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            // the core's least value is only trusted once it has settled
            if (state == WAIT && state_nx == DONE && op_q) rsp_data <= core_data_lt_o;
            if (state == DONE && !err_q) count <= op_q ? count - 1'b1 : count + 1'b1;
        end
    end
endmodule

// File: tb/tb_quickq_scheduler.sv
// tb_quickq_scheduler: directed vectors against a small behavioural quickQ core model.
module tb_quickq_scheduler;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int OP_LAT = 4;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid, req_op, req_ready, rsp_valid, core_mux1_sel;
    logic [DW-1:0] req_data0, req_data1, rsp_data, core_to_register, core_data_lt_o;
    logic rsp_err, core_enq, core_deq, core_regenb, core_next_node, full, empty;
    logic [3:0] count;
    int vectors = 0;
    int miscompares = 0;
    int n_deq = 0;
    int lat, regen_at, enq_at, d0;
    logic err;
    logic [1:0] vld;
    logic [DW-1:0] regq;
    int q[$];

    quickq_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .OP_LAT(OP_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .core_enq(core_enq), .core_deq(core_deq), .core_regenb(core_regenb),
        .core_mux1_sel(core_mux1_sel), .core_to_register(core_to_register),
        .core_next_node(core_next_node), .core_data_lt_o(core_data_lt_o),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // behavioural core: register load, insert on enq, pop-minimum on deq
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            regq <= '0;
            core_data_lt_o <= '0;
        end else begin
            if (core_regenb) regq <= core_to_register;
            if (core_enq) q.push_back(int'(regq));
            if (core_deq && q.size() > 0) begin
                int mi = 0;
                for (int i = 1; i < q.size(); i++) if (q[i] < q[mi]) mi = i;
                core_data_lt_o <= DW'(q[mi]);
                q.delete(mi);
            end
        end
        n_deq <= n_deq + int'(core_deq);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic do_req(input int port, input logic op, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        lat = -1; regen_at = -1; enq_at = -1; err = 1'bx; vld = 2'bxx;
        @(posedge clk); #1;
        req_valid[port] = 1'b1;
        req_op[port] = op;
        if (port == 0) req_data0 = d; else req_data1 = d;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = req_ready[port];
        end
        if (!got) begin
            check("grant_timeout", 0, 1);
            req_valid[port] = 1'b0;
            return;
        end
        @(posedge clk); #1 req_valid[port] = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (core_regenb && regen_at < 0) regen_at = n;
            if (core_enq && enq_at < 0) enq_at = n;
            if (rsp_valid != 2'b00) begin
                lat = n;
                vld = rsp_valid;
                err = rsp_err;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        rst = 1'b0; req_valid = '0; req_op = '0; req_data0 = '0; req_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", {full, empty}, 2'b01);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        check("rst_core", {core_enq, core_deq, core_regenb, core_next_node, core_mux1_sel, core_to_register}, 0);
        @(posedge clk); #1 rst = 1'b1;

        d0 = n_deq;
        do_req(0, 1'b1, 0);
        check("deq_empty_lat", lat, 1);
        check("deq_empty_err", {vld, err}, {2'b01, 1'b1});
        check("deq_empty_nopulse", n_deq - d0, 0);
        check("deq_empty_count", count, 0);

        do_req(0, 1'b0, 5);
        check("enq5_regen_at", regen_at, 1);
        check("enq5_enq_at", enq_at, 2);
        check("enq5_lat", lat, OP_LAT + 3);
        check("enq5_rsp", {vld, err}, {2'b01, 1'b0});
        check("enq5_count", count, 1);

        do_reset();
        do_req(0, 1'b0, 9);
        do_req(0, 1'b0, 5);
        do_req(0, 1'b0, 7);
        check("three_count", count, 3);
        d0 = n_deq;
        do_req(0, 1'b1, 0);
        check("deq_lat", lat, OP_LAT + 2);
        check("deq_rsp", {vld, err}, {2'b01, 1'b0});
        check("deq_pulses", n_deq - d0, 1);
        check("deq_data", rsp_data, 5);
        check("deq_count", count, 2);

        // abort an enqueue while the core is settling
        @(posedge clk); #1 req_valid[0] = 1'b1; req_op[0] = 1'b0; req_data0 = 11;
        @(negedge clk); check("abort_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); check("abort_in_wait", core_next_node, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_core", {core_enq, core_deq, core_regenb, core_next_node, core_mux1_sel, core_to_register}, 0);
        check("abort_count", count, 0);
        check("abort_rsp_data", rsp_data, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= (rsp_valid != 2'b00);
        end
        check("abort_no_rsp", seen, 0);
        do_req(1, 1'b1, 0);
        check("abort_next_lat", lat, 1);
        check("abort_next_rsp", {vld, err}, {2'b10, 1'b1});

        do_reset();
        @(posedge clk); #1 req_valid = 2'b11; req_op = 2'b00; req_data0 = 21; req_data1 = 42;
        for (int k = 0; k <= DEPTH; k++) begin
            logic [1:0] g;
            g = 2'b00;
            for (int w = 0; w < 40 && g == 2'b00; w++) begin
                @(negedge clk);
                g = req_ready;
            end
            check($sformatf("fill_grant%0d", k), g, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk);
            vld = 2'b00;
            for (int w = 0; w < 40 && vld == 2'b00; w++) begin
                @(negedge clk);
                vld = rsp_valid;
                err = rsp_err;
            end
            if (k == DEPTH) req_valid = 2'b00;
            check($sformatf("fill_rsp%0d", k), {vld, err}, {g, 1'(k == DEPTH)});
        end
        @(posedge clk); #1;
        check("fill_full", {full, count}, {1'b1, 4'(DEPTH)});

        do_reset();
        req_valid = 2'b11; req_op = 2'b10;
        @(negedge clk);
`ifdef QQ_SCHED_DEQ_PRIO_EN
        check("deq_prio_grant", req_ready, 2'b10);
`else
        check("deq_prio_grant", req_ready, 2'b01);
`endif
        @(posedge clk);
        req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
